// File: rtl/game_sprite_motion_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | game_sprite_motion_pkg                                                  |
// | Shared game geometry: screen size, sprite size and coordinate widths.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package game_sprite_motion_pkg;

    localparam int GAME_X_WIDTH       = 11;
    localparam int GAME_Y_WIDTH       = 11;
    localparam int GAME_DX_WIDTH      = 3;
    localparam int GAME_DY_WIDTH      = 3;
    localparam int GAME_SPRITE_WIDTH  = 8;
    localparam int GAME_SPRITE_HEIGHT = 8;
    localparam int GAME_SCREEN_WIDTH  = 640;
    localparam int GAME_SCREEN_HEIGHT = 480;
    localparam int GAME_UPDATE_PERIOD = 16;

endpackage
`default_nettype wire

// File: rtl/game_sprite_tick_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | game_sprite_tick_timer                                                  |
// | Free-running period counter producing one motion tick per period.      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module game_sprite_tick_timer
    import game_sprite_motion_pkg::*;
#(
    parameter int UPDATE_PERIOD = GAME_UPDATE_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              c_cw   = $clog2(UPDATE_PERIOD);
    localparam logic [c_cw-1:0] c_last = c_cw'(UPDATE_PERIOD - 1);

    logic [c_cw-1:0] cnt_q;
    logic [c_cw-1:0] cnt_d;
    logic            w_at_last;

    assign w_at_last = (cnt_q == c_last);
    // A clear (position write) wins over a tick on the same cycle.
    assign tick      = enable & w_at_last & ~clear;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable || clear || w_at_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_sprite_motion.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | game_sprite_motion                                                      |
// | One sprite's position/velocity, on-screen flag and registered hit.      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module game_sprite_motion
    import game_sprite_motion_pkg::*;
#(
    parameter int X_WIDTH       = GAME_X_WIDTH,
    parameter int Y_WIDTH       = GAME_Y_WIDTH,
    parameter int DX_WIDTH      = GAME_DX_WIDTH,
    parameter int DY_WIDTH      = GAME_DY_WIDTH,
    parameter int SPRITE_WIDTH  = GAME_SPRITE_WIDTH,
    parameter int SPRITE_HEIGHT = GAME_SPRITE_HEIGHT,
    parameter int SCREEN_WIDTH  = GAME_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = GAME_SCREEN_HEIGHT,
    parameter int UPDATE_PERIOD = GAME_UPDATE_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sprite_write_xy,
    input  logic                sprite_write_dxy,
    input  logic [X_WIDTH-1:0]  sprite_write_x,
    input  logic [Y_WIDTH-1:0]  sprite_write_y,
    input  logic [DX_WIDTH-1:0] sprite_write_dx,
    input  logic [DY_WIDTH-1:0] sprite_write_dy,
    input  logic                sprite_enable_update,
    input  logic [X_WIDTH-1:0]  pixel_x,
    input  logic [Y_WIDTH-1:0]  pixel_y,
    output logic [X_WIDTH-1:0]  sprite_x,
    output logic [Y_WIDTH-1:0]  sprite_y,
    output logic                sprite_within_screen,
    output logic                sprite_out_hit
);

    localparam logic signed [X_WIDTH:0] c_scr_w = (X_WIDTH + 1)'(SCREEN_WIDTH);
    localparam logic signed [Y_WIDTH:0] c_scr_h = (Y_WIDTH + 1)'(SCREEN_HEIGHT);
    localparam logic signed [X_WIDTH:0] c_spr_w = (X_WIDTH + 1)'(SPRITE_WIDTH);
    localparam logic signed [Y_WIDTH:0] c_spr_h = (Y_WIDTH + 1)'(SPRITE_HEIGHT);

    logic [X_WIDTH-1:0]  x_q,  x_d;
    logic [Y_WIDTH-1:0]  y_q,  y_d;
    logic [DX_WIDTH-1:0] dx_q, dx_d;
    logic [DY_WIDTH-1:0] dy_q, dy_d;
    logic                hit_q, hit_d;

    logic                    w_tick;
    logic [X_WIDTH-1:0]      w_dx_ext;
    logic [Y_WIDTH-1:0]      w_dy_ext;
    logic signed [X_WIDTH:0] w_x_s;
    logic signed [Y_WIDTH:0] w_y_s;
    logic signed [X_WIDTH:0] w_rel_x;
    logic signed [Y_WIDTH:0] w_rel_y;

    game_sprite_tick_timer #(
        .UPDATE_PERIOD (UPDATE_PERIOD)
    ) u_tick_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (sprite_enable_update),
        .clear  (sprite_write_xy),
        .tick   (w_tick)
    );

    assign w_dx_ext = {{(X_WIDTH - DX_WIDTH){dx_q[DX_WIDTH-1]}}, dx_q};
    assign w_dy_ext = {{(Y_WIDTH - DY_WIDTH){dy_q[DY_WIDTH-1]}}, dy_q};

    // Written velocity lands in the register only; a same-cycle tick still moves by the old one.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (sprite_write_xy) begin
            x_d = sprite_write_x;
            y_d = sprite_write_y;
        end else if (w_tick) begin
            x_d = x_q + w_dx_ext;
            y_d = y_q + w_dy_ext;
        end
        if (sprite_write_dxy) begin
            dx_d = sprite_write_dx;
            dy_d = sprite_write_dy;
        end
    end

    assign w_x_s = {x_q[X_WIDTH-1], x_q};
    assign w_y_s = {y_q[Y_WIDTH-1], y_q};

    assign sprite_within_screen = ~w_x_s[X_WIDTH] & (w_x_s < c_scr_w)
                                & ~w_y_s[Y_WIDTH] & (w_y_s < c_scr_h);

    // One extra bit keeps the offset exact for sprites hanging off the left/top edge.
    assign w_rel_x = $signed({1'b0, pixel_x}) - w_x_s;
    assign w_rel_y = $signed({1'b0, pixel_y}) - w_y_s;

    assign hit_d = ~w_rel_x[X_WIDTH] & (w_rel_x < c_spr_w)
                 & ~w_rel_y[Y_WIDTH] & (w_rel_y < c_spr_h);

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            hit_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            hit_q <= hit_d;
        end
    end

    assign sprite_x       = x_q;
    assign sprite_y       = y_q;
    assign sprite_out_hit = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sprite_motion.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_game_sprite_motion                                                   |
// | Directed scenarios plus random traffic against an integer motion model. |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_game_sprite_motion;

    localparam int c_xw = 11;
    localparam int c_yw = 11;
    localparam int c_period = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              sprite_write_xy, sprite_write_dxy;
    logic [c_xw-1:0]   sprite_write_x, pixel_x, sprite_x;
    logic [c_yw-1:0]   sprite_write_y, pixel_y, sprite_y;
    logic [2:0]        sprite_write_dx, sprite_write_dy;
    logic              sprite_enable_update;
    logic              sprite_within_screen, sprite_out_hit;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state as plain integers.
    int m_x, m_y, m_dx, m_dy, m_hit, m_run;

    always #5 clk = ~clk;

    game_sprite_motion u_dut (
        .clk                  (clk),
        .reset                (reset),
        .sprite_write_xy      (sprite_write_xy),
        .sprite_write_dxy     (sprite_write_dxy),
        .sprite_write_x       (sprite_write_x),
        .sprite_write_y       (sprite_write_y),
        .sprite_write_dx      (sprite_write_dx),
        .sprite_write_dy      (sprite_write_dy),
        .sprite_enable_update (sprite_enable_update),
        .pixel_x              (pixel_x),
        .pixel_y              (pixel_y),
        .sprite_x             (sprite_x),
        .sprite_y             (sprite_y),
        .sprite_within_screen (sprite_within_screen),
        .sprite_out_hit       (sprite_out_hit)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(input int v, input int w);
        int m;
        m = ((v % (1 << w)) + (1 << w)) % (1 << w);
        return (m >= (1 << (w - 1))) ? m - (1 << w) : m;
    endfunction

    // Advance one clock: update the model from the applied inputs, then compare at the falling edge.
    task automatic step();
        int px, py, tick;
        @(posedge clk);
        px = int'(pixel_x);
        py = int'(pixel_y);
        if (reset) begin
            m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_hit = 0; m_run = 0;
        end else begin
            m_hit = (px - m_x >= 0 && px - m_x <= 7 && py - m_y >= 0 && py - m_y <= 7) ? 1 : 0;
            if (sprite_enable_update && !sprite_write_xy) m_run++;
            else m_run = 0;
            tick = (m_run > 0 && (m_run % c_period) == 0) ? 1 : 0;
            if (sprite_write_xy) begin
                m_x = wrap(int'(sprite_write_x), c_xw);
                m_y = wrap(int'(sprite_write_y), c_yw);
            end else if (tick != 0) begin
                m_x = wrap(m_x + m_dx, c_xw);
                m_y = wrap(m_y + m_dy, c_yw);
            end
            if (sprite_write_dxy) begin
                m_dx = wrap(int'(sprite_write_dx), 3);
                m_dy = wrap(int'(sprite_write_dy), 3);
            end
        end
        @(negedge clk);
        check("x", int'($signed(sprite_x)), m_x);
        check("y", int'($signed(sprite_y)), m_y);
        check("within", int'(sprite_within_screen),
              (m_x >= 0 && m_x < 640 && m_y >= 0 && m_y < 480) ? 1 : 0);
        check("hit", int'(sprite_out_hit), m_hit);
        reset = 1'b0; sprite_write_xy = 1'b0; sprite_write_dxy = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int x, input int y, input int dx, input int dy);
        sprite_write_xy = 1'b1; sprite_write_dxy = 1'b1;
        sprite_write_x = c_xw'(x); sprite_write_y = c_yw'(y);
        sprite_write_dx = 3'(dx);  sprite_write_dy = 3'(dy);
        step();
    endtask

    initial begin
        reset = 1'b1; sprite_write_xy = 1'b0; sprite_write_dxy = 1'b0;
        sprite_write_x = '0; sprite_write_y = '0; sprite_write_dx = '0; sprite_write_dy = '0;
        sprite_enable_update = 1'b0; pixel_x = 11'd300; pixel_y = 11'd300;
        m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_hit = 0; m_run = 0;
        @(negedge clk);

        // Reset held two cycles, then idle enabled period
        step(); reset = 1'b1; step();
        check("rst_x", int'(sprite_x), 0);
        check("rst_within", int'(sprite_within_screen), 1);
        check("rst_hit", int'(sprite_out_hit), 0);
        sprite_enable_update = 1'b1; run(c_period);

        // Motion
        sprite_enable_update = 1'b0; load(100, 50, 2, -1);
        sprite_enable_update = 1'b1; run(15);
        check("mv_hold_x", int'($signed(sprite_x)), 100);
        step();
        check("mv1_x", int'($signed(sprite_x)), 102);
        check("mv1_y", int'($signed(sprite_y)), 49);
        run(16);
        check("mv2_x", int'($signed(sprite_x)), 104);
        check("mv2_y", int'($signed(sprite_y)), 48);

        // Exit right edge, then top edge
        load(638, 100, 1, 0); run(16);
        check("exit_x639", int'($signed(sprite_x)), 639);
        check("exit_in", int'(sprite_within_screen), 1);
        run(16);
        check("exit_x640", int'($signed(sprite_x)), 640);
        check("exit_out", int'(sprite_within_screen), 0);
        load(5, 0, 0, -1); run(16);
        check("exit_ym1", int'($signed(sprite_y)), -1);
        check("exit_yout", int'(sprite_within_screen), 0);

        // Clash: position write on tick cycle, then velocity write on tick cycle
        load(100, 50, 1, 1); run(15);
        sprite_write_xy = 1'b1; sprite_write_x = 11'd10; sprite_write_y = 11'd10; step();
        check("clash_x", int'($signed(sprite_x)), 10);
        run(15);
        check("clash_hold", int'($signed(sprite_x)), 10);
        step();
        check("clash_mv", int'($signed(sprite_x)), 11);
        run(15);
        sprite_write_dxy = 1'b1; sprite_write_dx = 3'd3; sprite_write_dy = 3'd1; step();
        check("dxy_old", int'($signed(sprite_x)), 12);
        run(16);
        check("dxy_new", int'($signed(sprite_x)), 15);

        // Hit window, including a sprite hanging off the left edge
        sprite_enable_update = 1'b0; load(20, 30, 0, 0);
        pixel_x = 11'd20; pixel_y = 11'd30; step();
        check("hit_tl", int'(sprite_out_hit), 1);
        pixel_x = 11'd27; pixel_y = 11'd37; step();
        check("hit_br", int'(sprite_out_hit), 1);
        pixel_x = 11'd28; pixel_y = 11'd30; step();
        check("hit_r", int'(sprite_out_hit), 0);
        pixel_x = 11'd19; step();
        check("hit_l", int'(sprite_out_hit), 0);
        load(-3, 30, 0, 0);
        pixel_x = 11'd0; step();
        check("hit_neg", int'(sprite_out_hit), 1);

        // Enable drop mid-period restarts the full period
        load(0, 0, 1, 1); sprite_enable_update = 1'b1; run(10);
        sprite_enable_update = 1'b0; run(3);
        sprite_enable_update = 1'b1; run(15);
        check("en_hold", int'($signed(sprite_x)), 0);
        step();
        check("en_tick", int'($signed(sprite_x)), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            sprite_enable_update = ($urandom_range(0, 9) != 0);
            sprite_write_xy = ($urandom_range(0, 39) == 0);
            sprite_write_dxy = ($urandom_range(0, 29) == 0);
            sprite_write_x = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 2047))
                                                         : 11'($urandom_range(0, 10) + 632);
            sprite_write_y = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 2047))
                                                         : 11'($urandom_range(0, 10) + 2042);
            sprite_write_dx = 3'($urandom_range(0, 7));
            sprite_write_dy = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) != 0) begin
                pixel_x = 11'($urandom_range(0, 639));
                pixel_y = 11'($urandom_range(0, 479));
            end else begin
                pixel_x = 11'((m_x < 2 ? 0 : (m_x > 630 ? 630 : m_x - 2)) + $urandom_range(0, 11));
                pixel_y = 11'((m_y < 2 ? 0 : (m_y > 470 ? 470 : m_y - 2)) + $urandom_range(0, 11));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
